cache_bus_arbiter: RTL and testbench
====================================

Name: cache_bus_arbiter

Overview:
- Two-master, one-slave arbiter that shares a single memory bus between two 2-way set-associative cache controllers (e.g. two processor cores).
- Each cache connects through its own master port. The port signals match the cache bus side: rd, wr, 5-bit block address, 16-bit write data, 16-bit read data, done.
- Round-robin grant; the command is latched at grant and held until memory completes, followed by one turnaround cycle.
- A watchdog flags memory transactions that never complete.

Parameters:
ADDR_W, 5, block address width (tag+set)
DATA_W, 16, block data width (two bytes)
TIMEOUT, 64, BUSY cycles without mem_done before timeout_err sets (>=2)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  reset, asynchronous, active-high
m0_rd  input  1  master 0 block read (fetch) request
m0_wr  input  1  master 0 block write-back request
m0_addr  input  ADDR_W  master 0 block address
m0_dout  input  DATA_W  master 0 write-back data
m0_din  output  DATA_W  read data to master 0
m0_done  output  1  completion strobe to master 0
m1_rd, m1_wr, m1_addr, m1_dout, m1_din, m1_done  as master 0, for master 1
mem_rd  output  1  memory read command
mem_wr  output  1  memory write command
mem_addr  output  ADDR_W  memory block address
mem_dout  output  DATA_W  memory write data
mem_din  input  DATA_W  memory read data
mem_done  input  1  memory completion
gnt  output  2  one-hot current owner (bit0 = master 0), 0 when idle
timeout_err  output  1  sticky watchdog flag

Behaviour:
- Request: req_i = mi_rd | mi_wr. If rd and wr are both high, treat as write (wr priority). Masters must drive valid 0/1 levels.
- States: IDLE, BUSY, TURN. Use one-hot or binary encoding; the observable behaviour is identical.
- Reset values:
  - state IDLE, gnt 0.
  - mem_rd/mem_wr 0; mem_addr and mem_dout 0.
  - m0_done/m1_done 0; m0_din/m1_din 0.
  - last_owner = 1, so master 0 wins the first tie.
  - timeout counter 0, timeout_err 0.
- IDLE:
  - No request: stay in IDLE with all outputs 0.
  - One request: grant that master.
  - Both requesting: grant the master != last_owner.
  - On the grant edge: load gnt, mem_rd, mem_wr, mem_addr and mem_dout from the winner's inputs into registers; go to BUSY; clear the timeout counter.
  - Latency: a request present before edge E gives a valid mem_* command after E.
- BUSY:
  - Registered command is held constant regardless of the master's inputs. A master dropping its request does not abort the transaction.
  - mi_done = mem_done & gnt[i] (combinational, same cycle). The non-owner's done is always 0.
  - mi_din = mem_din when gnt[i], else 0.
  - When mem_done is high at an edge: last_owner <= owner, clear mem_rd/mem_wr, go to TURN. gnt stays set through TURN.
  - Otherwise increment the timeout counter (saturating). When it reaches TIMEOUT-1, set timeout_err (sticky until reset). The transaction continues; it is not aborted.
- TURN:
  - One cycle with mem_rd=mem_wr=0 and done outputs 0. This lets the completed cache leave its requesting state.
  - Next: IDLE, gnt <= 0. Arbitration resumes in IDLE on the following edge.
  - Minimum spacing between consecutive grants: mem_done edge, then TURN, then IDLE, then new BUSY (3 edges).
- Back-to-back ownership: a cache doing write-back then fetch re-requests in IDLE. If the other master is requesting, the other master wins, since it is != last_owner.
- mem_done while IDLE or TURN is ignored and not forwarded.
- Reset mid-transaction: return asynchronously to reset values. The memory command drops immediately and no done pulse is generated.

Test Plan:
1. Reset, then m0_rd=1, addr=5'h0B. Expect: mem_rd=1, mem_addr=0B, gnt=01 one cycle later. Memory returns mem_din=16'hBEEF with mem_done after 3 cycles. Expect: m0_din=BEEF and m0_done=1 in that same cycle; m1_done=0; TURN then IDLE.
2. m0_wr and m1_rd both asserted in the same cycle after reset. Expect: master 0 granted first with mem_wr=1, mem_dout=m0_dout. After completion and TURN, master 1 granted with mem_rd=1. If master 0 re-requests at the same time, master 1 still wins.
3. m1_wr, addr=5'h1F, data=16'h1234, granted. Master changes m1_addr/m1_dout mid-BUSY. Expect: mem_addr=1F and mem_dout=1234 held until mem_done.
4. Grant master 0 and withhold mem_done for TIMEOUT cycles. Expect: timeout_err=1 at cycle TIMEOUT, still BUSY. A later mem_done completes normally; timeout_err stays 1 until reset.
5. Assert reset while BUSY. Expect: immediately mem_rd=mem_wr=0, gnt=0, no mi_done. After release, a pending m1 request is granted normally.
6. Pulse mem_done while IDLE and during TURN. Expect: no mi_done pulse and no state change.

Source files
------------

// File: rtl/cache_bus_arbiter.sv
// Two-master round-robin arbiter sharing one memory bus between two cache controllers.
// Each command is latched at grant, held until mem_done, then followed by one turnaround cycle.
module cache_bus_arbiter #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  // master 0
  input  logic              m0_rd,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_dout,
  output logic [DATA_W-1:0] m0_din,
  output logic              m0_done,
  // master 1
  input  logic              m1_rd,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_dout,
  output logic [DATA_W-1:0] m1_din,
  output logic              m1_done,
  // memory
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_dout,
  input  logic [DATA_W-1:0] mem_din,
  input  logic              mem_done,
  // status
  output logic [1:0]        gnt,
  output logic              timeout_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StTurn} state_e;

  state_e            state_q, state_d;
  logic [1:0]        gnt_q, gnt_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_dout_q, mem_dout_d;
  logic              last_owner_q, last_owner_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              err_q, err_d;

  logic              req0, req1, win1;
  logic              sel_rd, sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_dout;
  logic              busy;

  // Winner selection: a tie goes to whichever master did not own the bus last.
  always_comb begin
    req0     = m0_rd | m0_wr;
    req1     = m1_rd | m1_wr;
    win1     = (req0 & req1) ? ~last_owner_q : req1;
    sel_rd   = win1 ? m1_rd   : m0_rd;
    sel_wr   = win1 ? m1_wr   : m0_wr;
    sel_addr = win1 ? m1_addr : m0_addr;
    sel_dout = win1 ? m1_dout : m0_dout;
  end

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    mem_rd_d     = mem_rd_q;
    mem_wr_d     = mem_wr_q;
    mem_addr_d   = mem_addr_q;
    mem_dout_d   = mem_dout_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    err_d        = err_q;

    unique case (state_q)
      StIdle: begin
        if (req0 | req1) begin
          state_d    = StBusy;
          gnt_d      = win1 ? 2'b10 : 2'b01;
          // Write wins when a master raises both rd and wr.
          mem_wr_d   = sel_wr;
          mem_rd_d   = sel_rd & ~sel_wr;
          mem_addr_d = sel_addr;
          mem_dout_d = sel_dout;
          cnt_d      = '0;
        end
      end
      StBusy: begin
        if (mem_done) begin
          state_d      = StTurn;
          last_owner_d = gnt_q[1];
          mem_rd_d     = 1'b0;
          mem_wr_d     = 1'b0;
        end else begin
          if (cnt_q != CntMax) begin
            cnt_d = cnt_q + 1'b1;
          end
          // The watchdog only flags; the transaction keeps waiting for memory.
          if (cnt_d == CntMax) begin
            err_d = 1'b1;
          end
        end
      end
      StTurn: begin
        state_d    = StIdle;
        gnt_d      = 2'b00;
        mem_addr_d = '0;
        mem_dout_d = '0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      gnt_q        <= 2'b00;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_dout_q   <= '0;
      last_owner_q <= 1'b1;
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_dout_q   <= mem_dout_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
    end
  end

  // Completion is only forwarded while a transaction is outstanding.
  always_comb begin
    busy        = (state_q == StBusy);
    m0_done     = mem_done & gnt_q[0] & busy;
    m1_done     = mem_done & gnt_q[1] & busy;
    m0_din      = gnt_q[0] ? mem_din : '0;
    m1_din      = gnt_q[1] ? mem_din : '0;
    mem_rd      = mem_rd_q;
    mem_wr      = mem_wr_q;
    mem_addr    = mem_addr_q;
    mem_dout    = mem_dout_q;
    gnt         = gnt_q;
    timeout_err = err_q;
  end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Self-checking bench for cache_bus_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level arbitration model.
module tb_cache_bus_arbiter;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_rd, m0_wr, m1_rd, m1_wr;
  logic [4:0]  m0_addr, m1_addr, mem_addr;
  logic [15:0] m0_dout, m1_dout, m0_din, m1_din, mem_dout, mem_din;
  logic        m0_done, m1_done, mem_rd, mem_wr, mem_done, timeout_err;
  logic [1:0]  gnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: who owned the bus last (1 after reset) and the sticky error flag.
  int last_owner = 1;
  bit err_exp    = 1'b0;

  cache_bus_arbiter #(
    .ADDR_W (5),
    .DATA_W (16),
    .TIMEOUT(TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .m0_rd      (m0_rd),
    .m0_wr      (m0_wr),
    .m0_addr    (m0_addr),
    .m0_dout    (m0_dout),
    .m0_din     (m0_din),
    .m0_done    (m0_done),
    .m1_rd      (m1_rd),
    .m1_wr      (m1_wr),
    .m1_addr    (m1_addr),
    .m1_dout    (m1_dout),
    .m1_din     (m1_din),
    .m1_done    (m1_done),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_dout   (mem_dout),
    .mem_din    (mem_din),
    .mem_done   (mem_done),
    .gnt        (gnt),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic clear_masters();
    m0_rd = 0; m0_wr = 0; m0_addr = '0; m0_dout = '0;
    m1_rd = 0; m1_wr = 0; m1_addr = '0; m1_dout = '0;
  endtask

  // One full transaction: idle check, grant, held command for lat cycles, done, turnaround.
  task automatic run_txn(input logic r0, input logic w0, input logic [4:0] a0,
                         input logic [15:0] d0, input logic r1, input logic w1,
                         input logic [4:0] a1, input logic [15:0] d1, input int lat,
                         input bit scramble, input logic [15:0] rdata);
    int w;
    logic exp_rd, exp_wr;
    logic [4:0] ea;
    logic [15:0] ed;
    logic [1:0] eg, edone;
    bit eerr;
    @(negedge clk);
    m0_rd = r0; m0_wr = w0; m0_addr = a0; m0_dout = d0;
    m1_rd = r1; m1_wr = w1; m1_addr = a1; m1_dout = d1;
    mem_done = 1'($urandom % 2);
    mem_din  = 16'($urandom);
    #1;
    n_checks++;
    if ({gnt, mem_rd, mem_wr, mem_addr, mem_dout, m1_done, m0_done} !== '0) begin
      n_fail++;
      $display("FAIL idle_outputs: gnt=%b rd=%b wr=%b addr=%h dout=%h done=%b%b, required all 0",
               gnt, mem_rd, mem_wr, mem_addr, mem_dout, m1_done, m0_done);
    end
    n_checks++;
    if (timeout_err !== err_exp) begin
      n_fail++;
      $display("FAIL idle_timeout_err: got %b required %b", timeout_err, err_exp);
    end
    if (!(r0 | w0 | r1 | w1)) return;
    if ((r0 | w0) && (r1 | w1)) w = 1 - last_owner;
    else if (r0 | w0)           w = 0;
    else                        w = 1;
    exp_wr = (w == 1) ? w1 : w0;
    exp_rd = ((w == 1) ? r1 : r0) && !exp_wr;
    ea     = (w == 1) ? a1 : a0;
    ed     = (w == 1) ? d1 : d0;
    eg     = (w == 1) ? 2'b10 : 2'b01;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (scramble && c > 1) begin
        m0_rd = 1'($urandom); m0_wr = 1'($urandom); m0_addr = 5'($urandom); m0_dout = 16'($urandom);
        m1_rd = 1'($urandom); m1_wr = 1'($urandom); m1_addr = 5'($urandom); m1_dout = 16'($urandom);
      end
      mem_done = (c == lat);
      mem_din  = (c == lat) ? rdata : 16'($urandom);
      #1;
      edone = (c == lat) ? eg : 2'b00;
      eerr  = err_exp || (c >= TO);
      n_checks++;
      if (gnt !== eg || mem_rd !== exp_rd || mem_wr !== exp_wr || mem_addr !== ea ||
          mem_dout !== ed) begin
        n_fail++;
        $display("FAIL busy_cmd c=%0d: gnt=%b rd=%b wr=%b addr=%h dout=%h, required %b %b %b %h %h",
                 c, gnt, mem_rd, mem_wr, mem_addr, mem_dout, eg, exp_rd, exp_wr, ea, ed);
      end
      n_checks++;
      if ({m1_done, m0_done} !== edone || m0_din !== ((w == 0) ? mem_din : 16'h0) ||
          m1_din !== ((w == 1) ? mem_din : 16'h0)) begin
        n_fail++;
        $display("FAIL busy_return c=%0d: done=%b%b din0=%h din1=%h, required done=%b owner din=%h",
                 c, m1_done, m0_done, m0_din, m1_din, edone, mem_din);
      end
      n_checks++;
      if (timeout_err !== eerr) begin
        n_fail++;
        $display("FAIL busy_timeout_err c=%0d: got %b required %b", c, timeout_err, eerr);
      end
    end
    last_owner = w;
    err_exp    = err_exp || (lat >= TO);
    // Turnaround: masters leave their request state; a stray mem_done must be ignored.
    @(negedge clk);
    clear_masters();
    mem_done = 1'b1;
    #1;
    n_checks++;
    if (mem_rd !== 1'b0 || mem_wr !== 1'b0 || gnt !== eg || {m1_done, m0_done} !== 2'b00) begin
      n_fail++;
      $display("FAIL turn: rd=%b wr=%b gnt=%b done=%b%b, required 0 0 %b 00",
               mem_rd, mem_wr, gnt, m1_done, m0_done, eg);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_masters();
    mem_done = 1'b0;
    mem_din  = '0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({gnt, mem_rd, mem_wr, mem_addr, mem_dout, m0_done, m1_done, m0_din, m1_din,
         timeout_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: gnt=%b rd=%b wr=%b addr=%h dout=%h err=%b, required all 0",
               gnt, mem_rd, mem_wr, mem_addr, mem_dout, timeout_err);
    end
    reset = 1'b0;
    last_owner = 1;
    err_exp = 1'b0;
  endtask

  task automatic test_single_read();
    run_txn(1, 0, 5'h0B, 16'h0, 0, 0, 5'h0, 16'h0, 3, 0, 16'hBEEF);
  endtask

  // Tie goes to master 0 first; then master 1 wins the re-request tie.
  task automatic test_tie();
    run_txn(0, 1, 5'h03, 16'hA5A5, 1, 0, 5'h14, 16'h0, 2, 0, 16'h0);
    run_txn(1, 0, 5'h07, 16'h0, 1, 0, 5'h14, 16'h0, 2, 0, 16'h5A5A);
  endtask

  task automatic test_hold();
    run_txn(0, 0, 5'h00, 16'h0, 0, 1, 5'h1F, 16'h1234, 6, 1, 16'h0);
  endtask

  task automatic test_spurious_done();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_done = 1'($urandom % 2) | (i == 0);
      #1;
      n_checks++;
      if ({m1_done, m0_done} !== 2'b00 || gnt !== 2'b00 || mem_rd !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_mem_done: done=%b%b gnt=%b rd=%b, required 00 00 0",
                 m1_done, m0_done, gnt, mem_rd);
      end
    end
    mem_done = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_txn(1'($urandom), 1'($urandom), 5'($urandom), 16'($urandom),
              1'($urandom), 1'($urandom), 5'($urandom), 16'($urandom),
              int'($urandom_range(1, 5)), 1, 16'($urandom));
    end
  endtask

  task automatic test_timeout();
    run_txn(1, 0, 5'h11, 16'h0, 0, 0, 5'h0, 16'h0, TO + 4, 0, 16'hC0DE);
    // Sticky across a later normal transaction.
    run_txn(0, 0, 5'h0, 16'h0, 1, 0, 5'h02, 16'h0, 2, 1, 16'h0F0F);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    clear_masters();
    m0_wr = 1; m0_addr = 5'h09; m0_dout = 16'h7777;
    mem_done = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (gnt !== 2'b01 || mem_wr !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_grant: gnt=%b wr=%b, required 01 1", gnt, mem_wr);
    end
    reset = 1'b1;
    mem_done = 1'b1;
    #1;
    n_checks++;
    if (mem_rd !== 1'b0 || mem_wr !== 1'b0 || gnt !== 2'b00 || {m1_done, m0_done} !== 2'b00 ||
        timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_async: rd=%b wr=%b gnt=%b done=%b%b err=%b, required all 0",
               mem_rd, mem_wr, gnt, m1_done, m0_done, timeout_err);
    end
    @(negedge clk);
    reset = 1'b0;
    mem_done = 1'b0;
    clear_masters();
    last_owner = 1;
    err_exp = 1'b0;
    run_txn(0, 0, 5'h0, 16'h0, 1, 0, 5'h1A, 16'h0, 2, 0, 16'h4321);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish before it");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_single_read();
    test_tie();
    test_hold();
    test_spurious_done();
    test_random();
    test_timeout();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
